// File: rtl/dadda_pkg.sv
// dadda_pkg: Dadda height sequence, initial column heights and pipeline valid bits
package dadda_pkg;
  localparam int PIPE_DEPTH = 3;
  typedef struct packed {
    logic v0;
    logic v1;
    logic v2;
  } pipe_ctrl_t;
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int k = 1; k < j; k++) d = d * 3 / 2;
    return d;
  endfunction
  function automatic int col_height(input int width, input int col);
    return col < width ? col + 1 : 2 * width - 1 - col;
  endfunction
  function automatic int dadda_stages(input int h);
    int n;
    n = 0;
    for (int j = 1; j < 32; j++) if (dadda_height(j) < h) n = j;
    return n;
  endfunction
endpackage

// File: rtl/dadda_reduce.sv
// dadda_reduce: partial products and Dadda tree to two rows; DADDA_APPROX_LSB_EN ORs the low columns
module dadda_reduce import dadda_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SIGNED = 0,
  parameter int APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] sum_row,
  output logic [2*WIDTH-1:0] carry_row
);
  localparam int NC = 2 * WIDTH;
  localparam int MAXH = col_height(WIDTH, WIDTH - 1) + 1;
  localparam int NST = dadda_stages(WIDTH);
`ifdef DADDA_APPROX_LSB_EN
  localparam int AC = APPROX_COLS;
  if (APPROX_COLS >= NC) begin : g_bad_cols
    $error("APPROX_COLS must be less than 2*WIDTH");
  end
`else
  localparam int AC = 0 * APPROX_COLS;
`endif
  function automatic logic pick(input logic [MAXH-1:0] v, input int p);
    return 1'(v >> p);
  endfunction
  always_comb begin
    logic [MAXH-1:0] cur [NC];
    logic [MAXH-1:0] nxt [NC];
    int h [NC];
    int nh [NC];
    int rem, p, d;
    logic x, y, z, sv, co, pb;
    logic [NC-1:0] lo;
    rem = 0;
    p = 0;
    d = 0;
    x = 1'b0;
    y = 1'b0;
    z = 1'b0;
    sv = 1'b0;
    co = 1'b0;
    pb = 1'b0;
    lo = '0;
    sum_row = '0;
    carry_row = '0;
    for (int c = 0; c < NC; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      h[c] = 0;
      nh[c] = 0;
    end
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        pb = (a[i] & b[j]) ^ (SIGNED != 0 && ((i == WIDTH - 1) != (j == WIDTH - 1)));
        cur[i + j] = cur[i + j] | (MAXH'(pb) << h[i + j]);
        h[i + j]++;
      end
    if (SIGNED != 0) begin
      cur[WIDTH] = cur[WIDTH] | (MAXH'(1) << h[WIDTH]);
      h[WIDTH]++;
      cur[NC-1] = cur[NC-1] | (MAXH'(1) << h[NC-1]);
      h[NC-1]++;
    end
    for (int c = 0; c < AC; c++) begin
      lo[c] = |cur[c];
      cur[c] = '0;
      h[c] = 0;
    end
    for (int s = NST; s >= 1; s--) begin
      d = dadda_height(s);
      for (int c = 0; c < NC; c++) begin
        nxt[c] = '0;
        nh[c] = 0;
      end
      for (int c = 0; c < NC; c++) begin
        rem = h[c];
        p = 0;
        for (int k = 0; k < MAXH; k++)
          if (rem >= 2 && nh[c] + rem > d) begin
            x = pick(cur[c], p);
            y = pick(cur[c], p + 1);
            z = pick(cur[c], p + 2);
            if (rem == 2 || nh[c] + rem == d + 1) begin
              sv = x ^ y;
              co = x & y;
              p += 2;
              rem -= 2;
            end else begin
              sv = x ^ y ^ z;
              co = (x & y) | (z & (x ^ y));
              p += 3;
              rem -= 3;
            end
            nxt[c] = nxt[c] | (MAXH'(sv) << nh[c]);
            nh[c]++;
            if (c + 1 < NC) begin
              nxt[c + 1] = nxt[c + 1] | (MAXH'(co) << nh[c + 1]);
              nh[c + 1]++;
            end
          end
        for (int k = 0; k < MAXH; k++)
          if (k < rem) begin
            nxt[c] = nxt[c] | (MAXH'(pick(cur[c], p + k)) << nh[c]);
            nh[c]++;
          end
      end
      cur = nxt;
      h = nh;
    end
    for (int c = 0; c < NC; c++) begin
      sum_row[c] = c < AC ? lo[c] : pick(cur[c], 0);
      carry_row[c] = pick(cur[c], 1);
    end
  end
endmodule

// File: rtl/dadda_mul_pipe.sv
// dadda_mul_pipe: 3-stage valid/ready Dadda multiplier with prefix CLA; DADDA_APPROX_LSB_EN selects approximate low columns
module dadda_mul_pipe import dadda_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SIGNED = 0,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic [1:0]         occupancy
);
  localparam int NC = 2 * WIDTH;
  pipe_ctrl_t v;
  logic rdy0, rdy1, rdy2;
  logic [WIDTH-1:0] a0, b0;
  logic [NC-1:0] sum_row, carry_row, sum1, carry1, cla_sum;
  assign rdy2 = ~v.v2 | out_ready;
  assign rdy1 = ~v.v1 | rdy2;
  assign rdy0 = ~v.v0 | rdy1;
  assign in_ready = rdy0;
  assign out_valid = v.v2;
  assign occupancy = 2'(v.v0) + 2'(v.v1) + 2'(v.v2);
  dadda_reduce #(.WIDTH(WIDTH), .SIGNED(SIGNED), .APPROX_COLS(APPROX_COLS)) u_reduce (
    .a(a0),
    .b(b0),
    .sum_row(sum_row),
    .carry_row(carry_row)
  );
  always_comb begin
    logic [NC-1:0] g, p;
    g = sum1 & carry1;
    p = sum1 ^ carry1;
    for (int k = 1; k < NC; k = k * 2) begin
      g = g | (p & (g << k));
      p = p & (p << k);
    end
    cla_sum = sum1 ^ carry1 ^ {g[NC-2:0], 1'b0};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      a0 <= '0;
      b0 <= '0;
      sum1 <= '0;
      carry1 <= '0;
      out <= '0;
    end else begin
      if (rdy0) v.v0 <= in_valid;
      if (rdy1) v.v1 <= v.v0;
      if (rdy2) v.v2 <= v.v1;
      if (rdy0 && in_valid) begin
        a0 <= in1;
        b0 <= in2;
      end
      if (rdy1 && v.v0) begin
        sum1 <= sum_row;
        carry1 <= carry_row;
      end
      if (rdy2 && v.v1) out <= cla_sum;
    end
endmodule
